and_or_dual_path: RTL and testbench
===================================

Name: and_or_dual_path

Overview:
- Computes bitwise AND and bitwise OR of two operand vectors along two parallel paths.
- Combinational path: outputs follow the inputs with zero latency.
- Registered path: the same functions, delayed by a configurable number of clock stages, plus a fill indicator.
- Used as a reference block where a glitch-free, clock-aligned copy of simple logic sits next to its unclocked equivalent.

Parameters:
- WIDTH, 1, bit width of operands and of every data output; legal range 1..32.
- STAGES, 1, register stages on the registered path; legal range 1..8. An illegal value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_comb  output  WIDTH  a & b, combinational.
- d_comb  output  WIDTH  a | b, combinational.
- c_reg  output  WIDTH  a & b, delayed STAGES cycles.
- d_reg  output  WIDTH  a | b, delayed STAGES cycles.
- reg_valid  output  1  high once the registered pipeline holds data sampled after reset release.

Behaviour:
- Combinational path:
  - c_comb = a & b and d_comb = a | b, bitwise.
  - No clock or reset dependency, including while rst_n = 0.
- Registered path:
  - Stage 1 captures {a & b, a | b} on each rising clk edge.
  - Stage k+1 captures stage k.
  - c_reg and d_reg are driven from stage STAGES.
  - Latency: a value on a/b that is stable before rising edge N appears on c_reg/d_reg after edge N+STAGES-1.
  - For STAGES = 1 that is the same edge.
- Reset:
  - An edge with rst_n = 0 clears every stage to 0: c_reg = 0, d_reg = 0, reg_valid = 0.
  - Reset dominates data capture on that edge.
- reg_valid:
  - A STAGES-deep shift of 1s, cleared by reset.
  - It rises on the STAGES-th rising edge with rst_n = 1 after reset, then stays high until the next reset.
- Reset mid-operation: all in-flight stages are discarded on the reset edge, with no partial flush. After release, the fill sequence restarts from zero.
- Inputs changing every cycle: each cycle's sample propagates independently, with no merging or hold.
- Power-up before the first reset: outputs are undefined. Verification starts only after at least one reset edge.
- The registered outputs never glitch between edges. They change only immediately after a rising clk.

Decomposition:
- Shared package: WIDTH_MAX = 32 and STAGES_MAX = 8, used for parameter range checks.
- Sub-module and_or_core, instantiated twice (once per path):
  - Purely combinational, parameter WIDTH, inputs a and b, outputs and_o and or_o.
  - Guarantees the two paths compute identical functions.
- The pipeline is a generate loop in the top module, not a separate module.

Test Plan:
- Truth table, WIDTH = 1, STAGES = 1, clock period 6, each pattern held 30 time units (5 edges), sequence (a,b) = 00, 01, 10, 11:
  - Combinational outputs must be (c_comb,d_comb) = 00, 01, 01, 11 immediately.
  - Registered outputs must show the same values after the first rising edge of each pattern.
- Latency, STAGES = 3:
  - Apply a = 1, b = 1 after reset.
  - c_reg must be 0 after edges 1 and 2, and 1 after edge 3.
  - reg_valid must go high on edge 3.
- Reset mid-stream, STAGES = 2:
  - With reg_valid = 1 and a = b = 1, assert rst_n = 0 for one edge.
  - On that edge c_reg, d_reg and reg_valid must all be 0.
  - After release, reg_valid must return on the 2nd edge.
- Vector, WIDTH = 8, STAGES = 1:
  - Apply a = 0xF0, b = 0x3C.
  - c_comb must be 0x30 and d_comb 0xFC at once; c_reg and d_reg must match after one edge.
- Per-cycle toggling, STAGES = 2:
  - Alternate (a,b) between 11 and 00 every edge.
  - c_reg must alternate 1/0, lagging the input by 2 edges, with no stuck or duplicated samples.
- Combinational path during reset:
  - Hold rst_n = 0 and apply a = 1, b = 0.
  - d_comb must be 1 while d_reg stays 0.

Source files
------------

// File: rtl/and_or_dual_path_pkg.sv
// and_or_dual_path_pkg: shared limits for the dual-path AND/OR block.
package and_or_dual_path_pkg;
  localparam int WIDTH_MAX = 32;
  localparam int STAGES_MAX = 8;
endpackage

// File: rtl/and_or_dual_path_if.sv
// and_or_dual_path_if: operand inputs and both result paths of the dual-path block.
interface and_or_dual_path_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c_comb;
  logic [WIDTH-1:0] d_comb;
  logic [WIDTH-1:0] c_reg;
  logic [WIDTH-1:0] d_reg;
  logic reg_valid;
  modport master (output a, b, input c_comb, d_comb, c_reg, d_reg, reg_valid);
  modport slave (input a, b, output c_comb, d_comb, c_reg, d_reg, reg_valid);
endinterface

// File: rtl/and_or_dual_path_core.sv
// and_or_core: bitwise AND and OR shared by both paths so they stay identical.
module and_or_core #(parameter int WIDTH = 1) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_o,
  output logic [WIDTH-1:0] or_o
);
  assign and_o = a & b;
  assign or_o = a | b;
endmodule

// File: rtl/and_or_dual_path.sv
// and_or_dual_path: unclocked AND/OR next to a STAGES-deep registered copy with fill flag.
module and_or_dual_path
  import and_or_dual_path_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int STAGES = 1
) (
  input logic clk,
  input logic rst_n,
  and_or_dual_path_if.slave bus
);
  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("and_or_dual_path: WIDTH %0d out of range", WIDTH);
  end
  if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("and_or_dual_path: STAGES %0d out of range", STAGES);
  end
  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  and_or_core #(.WIDTH(WIDTH)) u_comb (
    .a(bus.a), .b(bus.b), .and_o(bus.c_comb), .or_o(bus.d_comb)
  );
  and_or_core #(.WIDTH(WIDTH)) u_reg (
    .a(bus.a), .b(bus.b), .and_o(and_r), .or_o(or_r)
  );
  // Each stage carries {valid, and, or}, so the fill flag shifts alongside the data.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [2*WIDTH:0] q;
    if (s == 0) begin : g_first
      always_ff @(posedge clk)
        q <= !rst_n ? '0 : {1'b1, and_r, or_r};
    end else begin : g_next
      always_ff @(posedge clk)
        q <= !rst_n ? '0 : g_stage[s-1].q;
    end
  end
  assign {bus.reg_valid, bus.c_reg, bus.d_reg} = g_stage[STAGES-1].q;
endmodule

// File: tb/tb_and_or_dual_path.sv
// tb_and_or_dual_path: directed steps on four configurations with a per-edge pipeline scoreboard.
module tb_and_or_dual_path;
  typedef logic [16:0] ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  ent_t q1[$], q2[$], q3[$], q8[$];
  always #3 clk = ~clk;
  and_or_dual_path_if #(.WIDTH(1)) i1 ();
  and_or_dual_path_if #(.WIDTH(1)) i2 ();
  and_or_dual_path_if #(.WIDTH(1)) i3 ();
  and_or_dual_path_if #(.WIDTH(8)) i8 ();
  and_or_dual_path #(.WIDTH(1), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  and_or_dual_path #(.WIDTH(1), .STAGES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  and_or_dual_path #(.WIDTH(1), .STAGES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));
  and_or_dual_path #(.WIDTH(8), .STAGES(1)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected registered output is the sample pushed STAGES edges ago, or zero while filling.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      q1.delete(); q2.delete(); q3.delete(); q8.delete();
    end else begin
      q1.push_back({1'b1, 8'(i1.a & i1.b), 8'(i1.a | i1.b)});
      q2.push_back({1'b1, 8'(i2.a & i2.b), 8'(i2.a | i2.b)});
      q3.push_back({1'b1, 8'(i3.a & i3.b), 8'(i3.a | i3.b)});
      q8.push_back({1'b1, i8.a & i8.b, i8.a | i8.b});
    end
    while (q1.size() > 1) void'(q1.pop_front());
    while (q2.size() > 2) void'(q2.pop_front());
    while (q3.size() > 3) void'(q3.pop_front());
    while (q8.size() > 1) void'(q8.pop_front());
    #1;
    chk("sb_s1", 32'({i1.reg_valid, 8'(i1.c_reg), 8'(i1.d_reg)}), 32'(q1.size() == 1 ? q1[0] : '0));
    chk("sb_s2", 32'({i2.reg_valid, 8'(i2.c_reg), 8'(i2.d_reg)}), 32'(q2.size() == 2 ? q2[0] : '0));
    chk("sb_s3", 32'({i3.reg_valid, 8'(i3.c_reg), 8'(i3.d_reg)}), 32'(q3.size() == 3 ? q3[0] : '0));
    chk("sb_w8", 32'({i8.reg_valid, i8.c_reg, i8.d_reg}), 32'(q8.size() == 1 ? q8[0] : '0));
  endtask

  initial begin
    logic [1:0] tt_c [4];
    logic [1:0] pat;
    tt_c = '{2'b00, 2'b01, 2'b01, 2'b11};
    {i1.a, i1.b, i2.a, i2.b, i3.a, i3.b} = '0;
    {i8.a, i8.b} = '0;
    step();
    step();
    chk("rst_valid", 32'(i3.reg_valid), 32'd0);
    i1.a = 1'b1;
    i1.b = 1'b0;
    #1;
    chk("rst_d_comb", 32'(i1.d_comb), 32'd1);
    step();
    chk("rst_d_reg", 32'(i1.d_reg), 32'd0);
    chk("rst_d_comb_hold", 32'(i1.d_comb), 32'd1);
    i3.a = 1'b1;
    i3.b = 1'b1;
    i8.a = 8'hF0;
    i8.b = 8'h3C;
    #1;
    chk("vec_c_comb", 32'(i8.c_comb), 32'h30);
    chk("vec_d_comb", 32'(i8.d_comb), 32'hFC);
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) begin
      pat = 2'(p);
      i1.a = pat[1];
      i1.b = pat[0];
      #1;
      chk("tt_comb", 32'({i1.c_comb, i1.d_comb}), 32'(tt_c[p]));
      for (int e = 0; e < 5; e++) begin
        step();
        if (e == 0) chk("tt_reg", 32'({i1.c_reg, i1.d_reg}), 32'(tt_c[p]));
        if (p == 0 && e < 2) chk("lat_early", 32'({i3.reg_valid, i3.c_reg}), 32'd0);
        if (p == 0 && e == 2) chk("lat_edge3", 32'({i3.reg_valid, i3.c_reg}), 32'b11);
        if (p == 0 && e == 0) chk("vec_reg", 32'({i8.c_reg, i8.d_reg}), 32'h30FC);
      end
    end
    for (int k = 0; k < 8; k++) begin
      i2.a = (k % 2 == 0);
      i2.b = (k % 2 == 0);
      step();
      if (k >= 1) chk("toggle", 32'(i2.c_reg), 32'((k - 1) % 2 == 0));
    end
    i2.a = 1'b1;
    i2.b = 1'b1;
    step();
    step();
    chk("mid_pre_valid", 32'({i2.reg_valid, i2.c_reg}), 32'b11);
    rst_n = 1'b0;
    step();
    chk("mid_rst", 32'({i2.reg_valid, i2.c_reg, i2.d_reg}), 32'd0);
    rst_n = 1'b1;
    step();
    chk("mid_edge1", 32'(i2.reg_valid), 32'd0);
    step();
    chk("mid_edge2", 32'({i2.reg_valid, i2.c_reg}), 32'b11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
